// File: rtl/fan_pkg.sv
// Shared constants for the fan row accumulator: line field layout, bank geometry and FSM state codes.
// The optional feature macro FAN_ACC_SAT_EN is consumed in fan_lane_adder.sv.
package fan_pkg;

  localparam int N_STACK  = 4;
  localparam int DW_DATA  = 32;
  localparam int DW_ROW   = 4;
  localparam int DW_CTRL  = 4;
  localparam int NUM_IN   = 4;

  localparam int DW_LANES = N_STACK * DW_DATA;
  localparam int DW_LINE  = DW_LANES + DW_ROW + DW_CTRL;
  localparam int DW_SLOT  = DW_LANES + DW_ROW;
  localparam int N_ROWS   = 2 ** DW_ROW;
  localparam int IDX_W    = $clog2(NUM_IN);

  localparam int DATA_LSB       = 0;
  localparam int ROW_LSB        = DATA_LSB + DW_LANES;
  localparam int CTRL_LSB       = ROW_LSB + DW_ROW;
  localparam int CTRL_VALID_BIT = DW_CTRL - 1;

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  typedef logic [DW_LINE-1:0] line_t;
  typedef logic [DW_SLOT-1:0] slot_t;

  function automatic logic line_valid(input line_t line);
    return line[CTRL_LSB + CTRL_VALID_BIT];
  endfunction

endpackage

// File: rtl/fan_lane_adder.sv
// N_STACK parallel lane adders. Wrap-around by default; with FAN_ACC_SAT_EN defined the lanes
// are signed and clamp to the representable range instead of overflowing.
module fan_lane_adder
  import fan_pkg::*;
#(
  parameter int LANES = N_STACK,
  parameter int WIDTH = DW_DATA
) (
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic [LANES*WIDTH-1:0] sum
);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Per-lane add; saturation keys off sign agreement of the operands versus the raw result.
  always_comb begin : lane_add
    logic [WIDTH-1:0] la;
    logic [WIDTH-1:0] lb;
    logic [WIDTH-1:0] ls;
    sum = {(LANES*WIDTH){1'b0}};
    la  = {WIDTH{1'b0}};
    lb  = {WIDTH{1'b0}};
    ls  = {WIDTH{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      la = a[l*WIDTH +: WIDTH];
      lb = b[l*WIDTH +: WIDTH];
      ls = la + lb;
`ifdef FAN_ACC_SAT_EN
      if ((la[WIDTH-1] == lb[WIDTH-1]) && (ls[WIDTH-1] != la[WIDTH-1])) begin
        ls = la[WIDTH-1] ? SAT_MIN : SAT_MAX;
      end else begin
        ls = la + lb;
      end
`endif
      sum[l*WIDTH +: WIDTH] = ls;
    end
  end

endmodule

// File: rtl/fan_row_accumulator.sv
// Row accumulator behind the last fan adder stage: serializes valid lines into a per-row bank,
// then drains touched rows in ascending order on flush. Build option: FAN_ACC_SAT_EN (saturating lanes).
module fan_row_accumulator
  import fan_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*DW_LINE-1:0] in,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW_ROW-1:0]         out_row,
  output logic [DW_LANES-1:0]       out_data,
  output logic                      done,
  output logic                      busy
);

  localparam logic [DW_ROW-1:0] PTR_ZERO  = {DW_ROW{1'b0}};
  localparam logic [DW_ROW-1:0] PTR_ONE   = {{(DW_ROW-1){1'b0}}, 1'b1};
  localparam logic [DW_ROW-1:0] PTR_LAST  = {DW_ROW{1'b1}};
  localparam logic [NUM_IN-1:0] PEND_NONE = {NUM_IN{1'b0}};

  logic [0:0]          state_r;
  logic                flush_pend_r;
  logic [DW_ROW-1:0]   ptr_r;
  logic                done_r;
  logic [NUM_IN-1:0]   pend_r;
  slot_t               slots_r [NUM_IN];
  logic [DW_LANES-1:0] acc_r [N_ROWS];
  logic [N_ROWS-1:0]   touched_r;

  logic                ser_empty_s;
  logic                accept_s;
  logic                retire_s;
  logic                step_s;
  logic                last_s;
  logic                hs_s;
  logic [NUM_IN-1:0]   in_mask_s;
  logic [IDX_W-1:0]    sel_idx_s;
  slot_t               sel_slot_s;
  logic [DW_ROW-1:0]   sel_row_s;
  logic [DW_LANES-1:0] sel_data_s;
  logic [DW_LANES-1:0] cur_acc_s;
  logic [DW_LANES-1:0] sum_s;
  logic [DW_LANES-1:0] wr_data_s;
  logic                unused_ctrl_s;

  assign ser_empty_s = (pend_r == PEND_NONE);
  assign in_ready    = (state_r == ACCUM) && ser_empty_s && !flush_pend_r;
  assign accept_s    = in_valid && in_ready;
  assign retire_s    = !ser_empty_s;
  assign out_valid   = (state_r == DRAIN) && touched_r[ptr_r];
  assign hs_s        = out_valid && out_ready;
  assign step_s      = (state_r == DRAIN) && (!touched_r[ptr_r] || out_ready);
  assign last_s      = step_s && (ptr_r == PTR_LAST);
  assign out_row     = out_valid ? ptr_r : PTR_ZERO;
  assign out_data    = out_valid ? acc_r[ptr_r] : {DW_LANES{1'b0}};
  assign done        = done_r;
  assign busy        = !ser_empty_s || flush_pend_r || (state_r == DRAIN);

  // Line-valid mask of the incoming word; the remaining ctrl bits carry nothing for this stage.
  always_comb begin
    in_mask_s     = PEND_NONE;
    unused_ctrl_s = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_mask_s[i]  = line_valid(in[i*DW_LINE +: DW_LINE]);
      unused_ctrl_s = unused_ctrl_s ^ (^in[i*DW_LINE + CTRL_LSB +: DW_CTRL-1]);
    end
  end

  // Lowest-index pending line retires first.
  always_comb begin
    sel_idx_s = {IDX_W{1'b0}};
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      sel_idx_s = pend_r[i] ? i[IDX_W-1:0] : sel_idx_s;
    end
  end

  // First touch of a row overwrites stale bank contents instead of adding to them.
  always_comb begin
    sel_slot_s = slots_r[sel_idx_s];
    sel_row_s  = sel_slot_s[ROW_LSB +: DW_ROW];
    sel_data_s = sel_slot_s[DATA_LSB +: DW_LANES];
    cur_acc_s  = acc_r[sel_row_s];
    wr_data_s  = touched_r[sel_row_s] ? sum_s : sel_data_s;
  end

  fan_lane_adder #(
    .LANES (N_STACK),
    .WIDTH (DW_DATA)
  ) u_lane_adder (
    .a   (cur_acc_s),
    .b   (sel_data_s),
    .sum (sum_s)
  );

  // ACCUM/DRAIN sequencing, flush latch and drain pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ACCUM;
      flush_pend_r <= 1'b0;
      ptr_r        <= PTR_ZERO;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ACCUM: begin
          if (flush_pend_r && ser_empty_s) begin
            state_r      <= DRAIN;
            flush_pend_r <= 1'b0;
            ptr_r        <= PTR_ZERO;
          end else if (flush) begin
            flush_pend_r <= 1'b1;
          end
        end
        DRAIN: begin
          if (step_s) begin
            ptr_r <= ptr_r + PTR_ONE;
            if (last_s) begin
              state_r <= ACCUM;
              done_r  <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ACCUM;
        end
      endcase
    end
  end

  // Serializer: latch row+data of all lines, then clear one pending bit per retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= PEND_NONE;
      for (int i = 0; i < NUM_IN; i++) begin
        slots_r[i] <= {DW_SLOT{1'b0}};
      end
    end else if (accept_s) begin
      pend_r <= in_mask_s;
      for (int i = 0; i < NUM_IN; i++) begin
        slots_r[i] <= in[i*DW_LINE +: DW_SLOT];
      end
    end else if (retire_s) begin
      pend_r[sel_idx_s] <= 1'b0;
    end
  end

  // Accumulator bank: single write port shared by retire (add) and drain (untouch).
  always_ff @(posedge clk) begin
    if (rst) begin
      touched_r <= {N_ROWS{1'b0}};
      for (int r = 0; r < N_ROWS; r++) begin
        acc_r[r] <= {DW_LANES{1'b0}};
      end
    end else if (retire_s) begin
      acc_r[sel_row_s]     <= wr_data_s;
      touched_r[sel_row_s] <= 1'b1;
    end else if (hs_s) begin
      touched_r[ptr_r] <= 1'b0;
    end
  end

endmodule
